// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, FSM encoding and helpers for the MAC accumulate datapath
package mac_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W = 40;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GP    = 2'd1,
        CARRY = 2'd2,
        SUM   = 2'd3
    } state_t;
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/prefix_node.sv
// prefix_node: Kogge-Stone black cell, (G,P) o (G',P') = (G | P&G', P&P')
module prefix_node (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;
endmodule

// File: rtl/prefix_accumulator.sv
// prefix_accumulator: signed accumulator with a multi-cycle Kogge-Stone adder
// (GP -> CARRY -> SUM), optional saturation and a sticky overflow flag.
module prefix_accumulator
    import mac_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] product,
    input  logic              acc_clear,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);
    localparam int LVL = clog2(ACC_W);
    localparam logic [ACC_W-1:0] W_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] W_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t r_state, w_next;
    logic [ACC_W-1:0] r_a, r_b, r_g, r_p, r_acc;
    logic [ACC_W-2:0] r_gc;
    logic r_ovf, r_out_valid;
    logic [ACC_W-1:0] w_gc, w_s, w_sum;
    logic w_ovf;

    // One signal pair per tree level keeps each level a distinct net.
    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        logic [ACC_W-1:0] w_gi, w_pi, w_go, w_po;
        logic w_unused_p;
        if (k == 0) begin : g_src
            assign w_gi = r_g;
            assign w_pi = r_p;
        end else begin : g_chain
            assign w_gi = g_lvl[k-1].w_go;
            assign w_pi = g_lvl[k-1].w_po;
        end
        for (genvar i = 0; i < ACC_W; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_node
                prefix_node u_node (
                    .i_g_hi(w_gi[i]),
                    .i_p_hi(w_pi[i]),
                    .i_g_lo(w_gi[i-(1<<k)]),
                    .i_p_lo(w_pi[i-(1<<k)]),
                    .o_g   (w_go[i]),
                    .o_p   (w_po[i])
                );
            end else begin : g_pass
                assign w_go[i] = w_gi[i];
                assign w_po[i] = w_pi[i];
            end
        end
        assign w_unused_p = ^{w_po, w_go[ACC_W-1]};
    end

    assign w_gc  = g_lvl[LVL-1].w_go;
    assign w_s   = r_p ^ {r_gc, 1'b0};
    assign w_ovf = (r_a[ACC_W-1] == r_b[ACC_W-1]) & (w_s[ACC_W-1] != r_a[ACC_W-1]);
    assign w_sum = (SATURATE && w_ovf) ? (r_a[ACC_W-1] ? W_MIN : W_MAX) : w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE)  ? (in_valid ? GP : IDLE) :
                 (r_state == GP)    ? CARRY :
                 (r_state == CARRY) ? SUM : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_g         <= '0;
            r_p         <= '0;
            r_gc        <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == SUM);
            if (r_state == IDLE) begin
                if (in_valid) begin
                    r_a <= {{(ACC_W-DATA_W){product[DATA_W-1]}}, product};
                    r_b <= acc_clear ? '0 : r_acc;
                    if (acc_clear) r_ovf <= 1'b0;
                end else if (acc_clear) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end
            end
            if (r_state == GP) begin
                r_g <= r_a & r_b;
                r_p <= r_a ^ r_b;
            end
            if (r_state == CARRY) r_gc <= w_gc[ACC_W-2:0];
            if (r_state == SUM) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_ovf;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;
endmodule
